// File: rtl/odd_chk_pkg.sv
// Shared types and defaults for the odd-sequence checker.
package odd_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_e;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_STEP         = 2;
    localparam int DEF_FAULT_THRESH = 3;

    localparam int ERR_CNT_W  = 8;
    localparam int WRAP_CNT_W = 16;

endpackage

// File: rtl/odd_chk_sat_cnt.sv
// Event counter with synchronous clear; SATURATE selects hold-at-max
// instead of rolling over to zero.
module odd_chk_sat_cnt #(
    parameter int W        = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !(SATURATE && (cnt_q == '1))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/odd_seq_checker.sv
// Monitors an odd-number count stream for parity and +STEP continuity.
// Statistics counters exist only when ODD_SEQ_CHECKER_STATS_EN is defined.
module odd_seq_checker
    import odd_chk_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int STEP         = DEF_STEP,
    parameter int FAULT_THRESH = DEF_FAULT_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      cnt_i,
    input  logic                  clr_i,
    output logic                  locked_o,
    output logic                  err_o,
    output logic                  wrap_o,
    output logic                  fault_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o,
    output logic [WRAP_CNT_W-1:0] wrap_cnt_o
);

    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [3:0]       THRESH_W = 4'(FAULT_THRESH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [3:0]       cons_q, cons_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] exp_val;
    logic             good;

    // Carry is dropped so 255 -> 1 is a legal step at WIDTH=8.
    assign exp_val = prev_q + STEP_W;
    assign good    = (cnt_i == exp_val) && cnt_i[0];

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        cons_d  = cons_q;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        if (clr_i) begin
            state_d = IDLE;
            prev_d  = '0;
            cons_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cnt_i[0]) begin
                        prev_d  = cnt_i;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    prev_d = cnt_i;
                    if (good) begin
                        cons_d = '0;
                        wrap_d = (cnt_i < prev_q);
                    end else begin
                        err_d  = 1'b1;
                        cons_d = cons_q + 4'd1;
                        if (cons_d == THRESH_W) begin
                            state_d = FAULT;
                        end
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
            cons_q  <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            cons_q  <= cons_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign locked_o = (state_q == TRACK);
    assign fault_o  = (state_q == FAULT);
    assign err_o    = err_q;
    assign wrap_o   = wrap_q;

`ifdef ODD_SEQ_CHECKER_STATS_EN
    // Counters take the same next-cycle pulses so they line up with err_o/wrap_o.
    odd_chk_sat_cnt #(
        .W        (ERR_CNT_W),
        .SATURATE (1'b1)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_i),
        .inc_i (err_d),
        .cnt_o (err_cnt_o)
    );

    odd_chk_sat_cnt #(
        .W        (WRAP_CNT_W),
        .SATURATE (1'b0)
    ) u_wrap_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_i),
        .inc_i (wrap_d),
        .cnt_o (wrap_cnt_o)
    );
`else
    assign err_cnt_o  = '0;
    assign wrap_cnt_o = '0;
`endif

endmodule
